// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants for the pipelined CLA adder/subtractor.
// Holds the default operand width, the default CLA group width and the op encoding.
package pipelined_cla_addsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result bus of the pipelined CLA adder/subtractor.
// Input side:  in_valid/in_ready handshake, a, b, cin, op_sub.
// Output side: out_valid/out_ready handshake, sum, cout, ovf, zero.
// master = producer/consumer (testbench or upstream logic), slave = the adder.
interface pipelined_cla_addsub_if
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/pipelined_cla_addsub_cla_block.sv
// cla_block: purely combinational BLOCK-bit carry-lookahead adder.
// Ports: x, y (BLOCK-bit addends), ci (carry in) -> s (BLOCK-bit sum), co (carry out).
module cla_block
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = ci;

  // Each carry is a flat sum of products: generate at bit j propagated
  // through bits j+1..i, plus the carry-in propagated through bits 0..i.
  for (genvar i = 0; i < BLOCK; i++) begin : g_carry
    logic [i+1:0] term;
    assign term[0] = g[i];
    for (genvar j = 0; j < i; j++) begin : g_term
      assign term[j+1] = g[j] & (&p[i:j+1]);
    end
    assign term[i+1] = ci & (&p[i:0]);
    assign c[i+1]    = |term;
  end

  assign s  = p ^ c[BLOCK-1:0];
  assign co = c[BLOCK];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit add/subtract, one CLA group resolved per stage.
// Ports: clk, rst_n (async, active-low), bus (slave side of pipelined_cla_addsub_if).
// Latency NGROUPS cycles, one operation per cycle, whole pipe stalls on back-pressure.
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_cla_addsub_if.slave  bus
);

  localparam int NGROUPS = WIDTH / BLOCK;

  if ((BLOCK < 1) || (WIDTH % BLOCK != 0)) begin : g_bad_cfg
    $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK");
  end

  logic             sub_en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             adv;
  logic             accept;
  logic             out_v;

  // Subtraction is a + ~b + !cin, so cout reads as NOT borrow.
  assign sub_en = (op_e'(bus.op_sub) == OP_SUB);
  assign b_eff  = sub_en ? ~bus.b : bus.b;
  assign c_eff  = sub_en ? ~bus.cin : bus.cin;

  assign adv          = !out_v || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
    logic [BLOCK-1:0]         x;
    logic [BLOCK-1:0]         y;
    logic [BLOCK-1:0]         s;
    logic                     ci;
    logic                     co;
    logic                     vin;
    logic [(k+1)*BLOCK-1:0]   s_nx;
    logic                     v_q;
    logic                     c_q;
    logic [(k+1)*BLOCK-1:0]   s_q;

    if (k == 0) begin : g_head
      assign x    = bus.a[BLOCK-1:0];
      assign y    = b_eff[BLOCK-1:0];
      assign ci   = c_eff;
      assign vin  = accept;
      assign s_nx = s;
    end else begin : g_body
      assign x    = g_stage[k-1].g_fwd.a_q[BLOCK-1:0];
      assign y    = g_stage[k-1].g_fwd.b_q[BLOCK-1:0];
      assign ci   = g_stage[k-1].c_q;
      assign vin  = g_stage[k-1].v_q;
      assign s_nx = {s, g_stage[k-1].s_q};
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .x  (x),
      .y  (y),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= 1'b0;
      else if (adv) v_q <= vin;
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        c_q <= co;
        s_q <= s_nx;
      end
    end

    // Operand groups not yet resolved ride along, shrinking by one group per stage.
    if (k < NGROUPS - 1) begin : g_fwd
      localparam int RW = WIDTH - (k + 1) * BLOCK;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;
      if (k == 0) begin : g_src
        always_ff @(posedge clk) begin
          if (adv) begin
            a_q <= bus.a[WIDTH-1:BLOCK];
            b_q <= b_eff[WIDTH-1:BLOCK];
          end
        end
      end else begin : g_src
        always_ff @(posedge clk) begin
          if (adv) begin
            a_q <= g_stage[k-1].g_fwd.a_q[RW+BLOCK-1:BLOCK];
            b_q <= g_stage[k-1].g_fwd.b_q[RW+BLOCK-1:BLOCK];
          end
        end
      end
    end

    // The top group carries the sign bits, so overflow and zero are settled here.
    if (k == NGROUPS - 1) begin : g_tail
      logic ovf_q;
      logic zero_q;
      always_ff @(posedge clk) begin
        if (adv) begin
          ovf_q  <= (x[BLOCK-1] == y[BLOCK-1]) && (s[BLOCK-1] != x[BLOCK-1]);
          zero_q <= (s_nx == '0);
        end
      end
    end
  end

  // Datapath registers are unreset; gating with the valid bit keeps idle outputs at 0.
  assign out_v         = g_stage[NGROUPS-1].v_q;
  assign bus.out_valid = out_v;
  assign bus.sum       = out_v ? g_stage[NGROUPS-1].s_q : '0;
  assign bus.cout      = out_v & g_stage[NGROUPS-1].c_q;
  assign bus.ovf       = out_v & g_stage[NGROUPS-1].g_tail.ovf_q;
  assign bus.zero      = out_v & g_stage[NGROUPS-1].g_tail.zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed self-checking bench: 32/8 instance for latency, overflow, bubbles,
// back-pressure and reset; 9/3 instance swept over all a with a b/cin/op table.
module tb_pipelined_cla_addsub;
  import pipelined_cla_addsub_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pipelined_cla_addsub_if #(.WIDTH(32)) bus32 ();
  pipelined_cla_addsub_if #(.WIDTH(9))  bus9 ();

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  pipelined_cla_addsub #(.WIDTH(9), .BLOCK(3)) u9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv32(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
    bus32.in_valid = v;
    bus32.a        = a;
    bus32.b        = b;
    bus32.cin      = cin;
    bus32.op_sub   = sub;
  endtask

  // {ovf, zero, cout, sum}
  function automatic logic [34:0] m32(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic sub);
    logic [31:0] be;
    logic        ce;
    logic [32:0] r;
    be = sub ? ~b : b;
    ce = sub ? ~cin : cin;
    r  = {1'b0, a} + {1'b0, be} + {32'd0, ce};
    return {(a[31] == be[31]) && (r[31] != a[31]), r[31:0] == 32'd0, r};
  endfunction

  function automatic logic [11:0] m9(input logic [8:0] a, input logic [8:0] b,
                                     input logic cin, input logic sub);
    logic [8:0] be;
    logic       ce;
    logic [9:0] r;
    be = sub ? ~b : b;
    ce = sub ? ~cin : cin;
    r  = {1'b0, a} + {1'b0, be} + {9'd0, ce};
    return {(a[8] == be[8]) && (r[8] != a[8]), r[8:0] == 9'd0, r};
  endfunction

  function automatic logic [34:0] obs32();
    return {bus32.ovf, bus32.zero, bus32.cout, bus32.sum};
  endfunction

  initial begin
    logic [34:0] q32[$];
    logic [11:0] q9[$];
    int          pat[4];
    int          b9[16];
    int          issued;
    int          got;
    logic [31:0] sa;
    logic [31:0] sb;
    logic [8:0]  a9;
    logic [8:0]  bb9;

    n_cmp = 0;
    n_bad = 0;
    pat   = '{1, 0, 0, 1};
    b9    = '{0, 1, 2, 3, 7, 8, 63, 64, 127, 128, 255, 256, 341, 170, 510, 511};

    rst_n = 1'b1;
    drv32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    bus9.in_valid   = 1'b0;
    bus9.a          = '0;
    bus9.b          = '0;
    bus9.cin        = 1'b0;
    bus9.op_sub     = 1'b0;
    bus9.out_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #21;
    chk("rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    chk("rst_outputs", {29'd0, obs32()}, 64'd0);
    chk("rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);

    // carry ripples through every group
    drv32(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, OP_ADD);
    tick();
    drv32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      chk("carry_lat_early", {63'd0, bus32.out_valid}, 64'd0);
      tick();
    end
    chk("carry_lat_valid", {63'd0, bus32.out_valid}, 64'd1);
    chk("carry_result", {29'd0, obs32()}, {29'd0, 1'b0, 1'b1, 1'b1, 32'h0});
    tick();
    chk("carry_drained", {63'd0, bus32.out_valid}, 64'd0);

    // signed overflow, then a borrowing subtract
    drv32(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, OP_ADD);
    tick();
    drv32(1'b1, 32'd5, 32'd7, 1'b0, OP_SUB);
    tick();
    drv32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("ovf_add", {29'd0, obs32()}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000});
    tick();
    chk("sub_borrow", {29'd0, obs32()}, {29'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
    tick();

    // bubbles 1,0,1,0 with junk operands on the idle slots
    drv32(1'b1, 32'd100, 32'd23, 1'b0, OP_ADD);
    tick();
    chk("bub_e1", {63'd0, bus32.out_valid}, 64'd0);
    drv32(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, OP_SUB);
    tick();
    chk("bub_e2", {63'd0, bus32.out_valid}, 64'd0);
    drv32(1'b1, 32'h10, 32'h20, 1'b1, OP_SUB);
    tick();
    chk("bub_e3", {63'd0, bus32.out_valid}, 64'd0);
    drv32(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD);
    tick();
    chk("bub_v1", {63'd0, bus32.out_valid}, 64'd1);
    chk("bub_r1", {29'd0, obs32()}, {29'd0, 3'b000, 32'h7B});
    tick();
    chk("bub_v2", {63'd0, bus32.out_valid}, 64'd0);
    chk("bub_r2_quiet", {29'd0, obs32()}, 64'd0);
    tick();
    chk("bub_v3", {63'd0, bus32.out_valid}, 64'd1);
    chk("bub_r3", {29'd0, obs32()}, {29'd0, 3'b000, 32'hFFFF_FFEF});
    tick();
    chk("bub_v4", {63'd0, bus32.out_valid}, 64'd0);

    // 16-op stream with out_ready cycling 1,0,0,1
    issued = 0;
    got    = 0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      bus32.out_ready = pat[cyc % 4][0];
      sa = issued * 32'h9E37_79B9 + 32'h1;
      sb = 32'h7F4A_7C15 ^ (issued << 3);
      if (issued < 16) drv32(1'b1, sa, sb, sa[0], sa[1]);
      else             drv32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      if (bus32.out_valid) begin
        if (q32.size() == 0) begin
          chk("stream_spurious", {63'd0, bus32.out_valid}, 64'd0);
        end else begin
          chk("stream_res", {29'd0, obs32()}, {29'd0, q32[0]});
          if (bus32.out_ready) begin
            void'(q32.pop_front());
            got++;
          end
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q32.push_back(m32(sa, sb, sa[0], sa[1]));
        issued++;
      end
      tick();
    end
    chk("stream_issued", issued, 64'd16);
    chk("stream_got", got, 64'd16);
    drv32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    tick();
    tick();
    chk("stream_idle", {63'd0, bus32.out_valid}, 64'd0);

    // reset while two ops are in flight and a third is offered
    drv32(1'b1, 32'd1, 32'd1, 1'b0, OP_ADD);
    tick();
    drv32(1'b1, 32'd2, 32'd2, 1'b0, OP_ADD);
    tick();
    drv32(1'b1, 32'd3, 32'd3, 1'b0, OP_ADD);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    tick();
    tick();
    drv32(1'b0, 32'd4, 32'd4, 1'b0, OP_ADD);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("midrst_rel_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_ghost", {63'd0, bus32.out_valid}, 64'd0);
    end
    drv32(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, OP_ADD);
    tick();
    drv32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("midrst_new_early", {63'd0, bus32.out_valid}, 64'd0);
    tick();
    chk("midrst_new_valid", {63'd0, bus32.out_valid}, 64'd1);
    chk("midrst_new_res", {29'd0, obs32()}, {29'd0, 3'b000, 32'h3333_3333});
    tick();

    // 9-bit / 3-bit-group instance: every a against a table of b, cin and op
    for (int a = 0; a < 512; a++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int m = 0; m < 4; m++) begin
          a9  = a[8:0];
          bb9 = b9[bi][8:0];
          bus9.in_valid = 1'b1;
          bus9.a        = a9;
          bus9.b        = bb9;
          bus9.cin      = m[0];
          bus9.op_sub   = m[1];
          #1;
          if (bus9.out_valid) begin
            if (q9.size() == 0) begin
              chk("w9_spurious", {63'd0, bus9.out_valid}, 64'd0);
            end else begin
              chk("w9_res", {52'd0, bus9.ovf, bus9.zero, bus9.cout, bus9.sum}, {52'd0, q9[0]});
              void'(q9.pop_front());
            end
          end
          if (bus9.in_ready) q9.push_back(m9(a9, bb9, m[0], m[1]));
          tick();
        end
      end
    end
    bus9.in_valid = 1'b0;
    for (int i = 0; i < 10 && q9.size() > 0; i++) begin
      if (bus9.out_valid) begin
        chk("w9_res", {52'd0, bus9.ovf, bus9.zero, bus9.cout, bus9.sum}, {52'd0, q9[0]});
        void'(q9.pop_front());
      end
      tick();
    end
    chk("w9_left", q9.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
